// File: rtl/async_reg_bank.sv
// rtl/async_reg_bank.sv - register/counter bank driven by strobes sampled in the clock domain
// Each channel loads d or increments on a configurable strobe edge; carry out allows ripple chaining.
module async_reg_bank #(
  parameter int                     WIDTH      = 8,
  parameter int                     CHANNELS   = 4,
  parameter logic [WIDTH-1:0]       RESET_VAL  = '0,
  parameter logic [WIDTH-1:0]       SET_VAL    = '1,
  parameter logic [CHANNELS-1:0]    FALL_MASK  = '0,
  parameter logic [CHANNELS-1:0]    COUNT_MASK = '0
) (
  input  logic                      clock,
  input  logic                      resb,
  input  logic [CHANNELS-1:0]       s,
  input  logic [CHANNELS-1:0]       r,
  input  logic [CHANNELS-1:0]       c,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       co,
  output logic [CHANNELS-1:0]       strobe_edge
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam bit FALL  = FALL_MASK[i];
    localparam bit COUNT = COUNT_MASK[i];

    logic [WIDTH-1:0] val_reg;
    logic [WIDTH-1:0] q_ch;
    logic             c_d;
    logic             edge_hit;

    // c_d is held at the post-edge level in reset, so gating with resb only hides transients
    always_comb begin
      edge_hit = 1'b0;
      if (resb)
        edge_hit = FALL ? (c_d & ~c[i]) : (~c_d & c[i]);
    end

    always_comb begin
      q_ch = val_reg;
      if (!resb)
        q_ch = RESET_VAL;
      else if (r[i])
        q_ch = RESET_VAL;
      else if (s[i])
        q_ch = SET_VAL;
      else if (edge_hit)
        q_ch = COUNT ? (val_reg + 1'b1) : d[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clock or negedge resb) begin
      if (!resb) begin
        val_reg <= RESET_VAL;
        c_d     <= ~FALL;
      end else begin
        val_reg <= q_ch;
        c_d     <= c[i];
      end
    end

    assign q[i*WIDTH +: WIDTH] = q_ch;
    assign strobe_edge[i]      = edge_hit;
    assign co[i]               = COUNT & edge_hit & (&val_reg) & ~r[i] & ~s[i] & resb;
  end

endmodule

// File: tb/tb_async_reg_bank.sv
// tb/tb_async_reg_bank.sv - scoreboard bench for async_reg_bank
// Stimulus pushes predicted outputs per cycle; a negedge monitor pops and compares.
module tb_async_reg_bank;

  logic        clock = 1'b0;
  logic        resb  = 1'b0;
  logic [3:0]  s     = '0;
  logic [3:0]  r     = '0;
  logic [3:0]  c     = 4'b0001;
  logic [31:0] d     = '0;
  logic [31:0] q;
  logic [3:0]  co;
  logic [3:0]  ed;

  logic        lo_s = 1'b0, lo_r = 1'b0, lo_c = 1'b0;
  logic        zero1 = 1'b0;
  logic [3:0]  zero4 = '0;
  logic [3:0]  lo_q, hi_q;
  logic        lo_co, hi_co, lo_ed, hi_ed;

  always #5 clock = ~clock;

  async_reg_bank #(.WIDTH(8), .CHANNELS(4), .FALL_MASK(4'b0010), .COUNT_MASK(4'b1100)) dut (
    .clock(clock), .resb(resb), .s(s), .r(r), .c(c), .d(d),
    .q(q), .co(co), .strobe_edge(ed));

  async_reg_bank #(.WIDTH(4), .CHANNELS(1), .COUNT_MASK(1'b1)) u_lo (
    .clock(clock), .resb(resb), .s(lo_s), .r(lo_r), .c(lo_c), .d(zero4),
    .q(lo_q), .co(lo_co), .strobe_edge(lo_ed));

  async_reg_bank #(.WIDTH(4), .CHANNELS(1), .COUNT_MASK(1'b1)) u_hi (
    .clock(clock), .resb(resb), .s(zero1), .r(zero1), .c(lo_co), .d(zero4),
    .q(hi_q), .co(hi_co), .strobe_edge(hi_ed));

  typedef struct packed {
    logic [31:0] q;
    logic [3:0]  co;
    logic [3:0]  ed;
    logic [3:0]  lo_q;
    logic        lo_co;
    logic        lo_ed;
    logic [3:0]  hi_q;
    logic        hi_co;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  int unsigned mval[4];
  bit          mprev[4];
  int unsigned lo_val = 0, hi_val = 0;
  bit          lo_prev = 1'b1, hi_prev = 1'b1;

  // Behavioural channel: value plus last seen strobe level
  task automatic model_chan(input bit rise, input bit cnt, input int w, input bit rb,
                            input bit rr, input bit ss, input bit cc, input int unsigned dval,
                            inout int unsigned val, inout bit prev,
                            output int unsigned qv, output bit cov, output bit edv);
    int unsigned maxv;
    maxv = (32'd1 << w) - 32'd1;
    cov  = 1'b0;
    edv  = 1'b0;
    if (!rb) begin
      qv   = 0;
      val  = 0;
      prev = rise;
    end else begin
      edv = rise ? (cc && !prev) : (!cc && prev);
      if (rr)       qv = 0;
      else if (ss)  qv = maxv;
      else if (edv) begin
        if (cnt) begin
          cov = (val == maxv);
          qv  = (val + 1) & maxv;
        end else begin
          qv = dval & maxv;
        end
      end else      qv = val;
      val  = qv;
      prev = cc;
    end
  endtask

  task automatic cycle();
    exp_t        e;
    int unsigned qv;
    bit          cov, edv;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      model_chan(i != 1, i >= 2, 8, resb, r[i], s[i], c[i], 32'(d[i*8 +: 8]),
                 mval[i], mprev[i], qv, cov, edv);
      e.q[i*8 +: 8] = qv[7:0];
      e.co[i]       = cov;
      e.ed[i]       = edv;
    end
    model_chan(1'b1, 1'b1, 4, resb, lo_r, lo_s, lo_c, 0, lo_val, lo_prev, qv, cov, edv);
    e.lo_q  = qv[3:0];
    e.lo_co = cov;
    e.lo_ed = edv;
    model_chan(1'b1, 1'b1, 4, resb, 1'b0, 1'b0, e.lo_co, 0, hi_val, hi_prev, qv, cov, edv);
    e.hi_q  = qv[3:0];
    e.hi_co = cov;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q",     q,            e.q);
        chk("co",    32'(co),      32'(e.co));
        chk("edge",  32'(ed),      32'(e.ed));
        chk("lo_q",  32'(lo_q),    32'(e.lo_q));
        chk("lo_co", 32'(lo_co),   32'(e.lo_co));
        chk("lo_ed", 32'(lo_ed),   32'(e.lo_ed));
        chk("hi_q",  32'(hi_q),    32'(e.hi_q));
        chk("hi_co", 32'(hi_co),   32'(e.hi_co));
      end
    end
  end

  task automatic lo_edges(input int n);
    for (int k = 0; k < n; k++) begin
      lo_c = 1'b1; cycle();
      lo_c = 1'b0; cycle();
    end
  endtask

  initial begin : stimulus
    for (int i = 0; i < 4; i++) begin
      mval[i]  = 0;
      mprev[i] = (i != 1);
    end
    @(posedge clock);
    #1;
    cycle(); cycle();
    resb = 1'b1; cycle(); cycle();
    d[7:0] = 8'hA5; c[0] = 1'b0; cycle();
    c[0] = 1'b1; cycle();
    d[7:0] = 8'h3C; cycle(); cycle();
    c[1] = 1'b1; d[15:8] = 8'h5A; cycle();
    c[1] = 1'b0; cycle();
    d[15:8] = 8'hFF; c[1] = 1'b1; cycle(); cycle();
    c[0] = 1'b0; cycle();
    r[0] = 1'b1; s[0] = 1'b1; c[0] = 1'b1; d[7:0] = 8'h77; cycle();
    r[0] = 1'b0; s[0] = 1'b0; cycle();
    c[0] = 1'b0; cycle();
    s[0] = 1'b1; c[0] = 1'b1; cycle();
    s[0] = 1'b0; cycle(); cycle();
    s[2] = 1'b1; cycle();
    s[2] = 1'b0; c[2] = 1'b1; cycle();
    c[2] = 1'b0; cycle();
    lo_edges(16);
    lo_edges(7);
    lo_c = 1'b1; resb = 1'b0; cycle();
    resb = 1'b1; cycle(); cycle();
    lo_c = 1'b0; cycle();
    lo_c = 1'b1; cycle();
    lo_c = 1'b0; cycle();
    lo_edges(14);
    lo_s = 1'b1; lo_c = 1'b1; cycle();
    lo_s = 1'b0; cycle();
    lo_c = 1'b0; cycle();
    for (int k = 0; k < 800; k++) begin
      resb = ($urandom_range(0, 63) != 0);
      r    = 4'($urandom) & 4'($urandom) & 4'($urandom);
      s    = 4'($urandom) & 4'($urandom) & 4'($urandom);
      c    = 4'($urandom);
      d    = $urandom;
      lo_c = 1'($urandom);
      lo_r = ($urandom_range(0, 31) == 0);
      lo_s = ($urandom_range(0, 31) == 0);
      cycle();
    end
    @(negedge clock);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
